cbb_pulse_synchronizer: RTL and testbench

- Brings a pulse or level event from a foreign, asynchronous domain into the local clock domain.
- Resolves metastability through a configurable register chain.
- Optionally stretches the synchronized event to a minimum width.
- Emits either a single-cycle pulse or the conditioned level.
- Sits at clock-domain boundaries as a common building block for control/strobe crossings.

---
 rtl/cbb_pulse_synchronizer.sv | 140 ++++++++++++++
 tb/tb_cbb_pulse_synchronizer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cbb_pulse_synchronizer.sv
// rtl/cbb_pulse_synchronizer.sv - asynchronous event to i_clk domain pulse/level synchronizer
//
// Purpose:
//   Carries an event from a foreign clock domain into i_clk through a
//   P_SYNC_STAGE flop chain, optionally stretches it to at least
//   P_EXTEN_MULT cycles, then emits either a one-cycle pulse per rising
//   edge (CARE-1) or the conditioned level (NOTCARE). Output is registered.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_pulse_src  event from the asynchronous domain (glitch-free register output)
//   o_pulse_dst  synchronized event in the i_clk domain
module cbb_pulse_synchronizer #(
    parameter string P_EXTEN_EN    = "DISABLE",
    parameter int    P_EXTEN_MULT  = 3,
    parameter int    P_SYNC_STAGE  = 2,
    parameter string P_PULSE_WIDTH = "CARE-1"
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse_src,
    output logic o_pulse_dst
);

    localparam bit L_EXT_EN = (P_EXTEN_EN == "ENABLE");
    localparam bit L_CARE1  = (P_PULSE_WIDTH == "CARE-1");

    generate
        if (P_SYNC_STAGE < 2) begin : g_bad_sync_stage
            $error("cbb_pulse_synchronizer: P_SYNC_STAGE must be >= 2");
        end
        if (P_EXTEN_MULT < 2) begin : g_bad_exten_mult
            $error("cbb_pulse_synchronizer: P_EXTEN_MULT must be >= 2");
        end
        if (!(P_EXTEN_EN == "ENABLE" || P_EXTEN_EN == "DISABLE")) begin : g_bad_exten_en
            $error("cbb_pulse_synchronizer: P_EXTEN_EN must be ENABLE or DISABLE");
        end
        if (!(P_PULSE_WIDTH == "CARE-1" || P_PULSE_WIDTH == "NOTCARE")) begin : g_bad_pulse_width
            $error("cbb_pulse_synchronizer: P_PULSE_WIDTH must be CARE-1 or NOTCARE");
        end
    endgenerate

    // Synchronizer chain: plain flop-to-flop, nothing in between.
    logic [P_SYNC_STAGE-1:0] sync_q, sync_d;
    // Parallel marker chain: bit k is set once chain flop k holds a real
    // sample taken after reset rather than a reset value.
    logic [P_SYNC_STAGE-1:0] valid_q, valid_d;
    // Armed once a genuine low has emerged from the chain since reset, so a
    // level that was already high across reset never counts as a new edge.
    logic arm_q, arm_d;
    logic sync_raw;
    logic sync_g;
    logic ext;
    logic out_d;

    assign sync_raw = sync_q[P_SYNC_STAGE-1];
    assign sync_g   = sync_raw & arm_q;

    always_comb begin
        sync_d  = {sync_q[P_SYNC_STAGE-2:0], i_pulse_src};
        valid_d = {valid_q[P_SYNC_STAGE-2:0], 1'b1};
        arm_d   = arm_q | (valid_q[P_SYNC_STAGE-1] & ~sync_raw);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            valid_q <= '0;
            arm_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            valid_q <= valid_d;
            arm_q   <= arm_d;
        end
    end

    generate
        if (L_EXT_EN) begin : g_stretch
            localparam int CW = $clog2(P_EXTEN_MULT);
            logic          sync_hist_q;
            logic [CW-1:0] cnt_q, cnt_d;

            // A rising edge (re)loads the window, so closely spaced events merge.
            always_comb begin
                cnt_d = cnt_q;
                if (sync_g & ~sync_hist_q) begin
                    cnt_d = CW'(P_EXTEN_MULT - 1);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync_hist_q <= 1'b0;
                    cnt_q       <= '0;
                end else begin
                    sync_hist_q <= sync_g;
                    cnt_q       <= cnt_d;
                end
            end

            assign ext = sync_g | (cnt_q != '0);
        end else begin : g_no_stretch
            assign ext = sync_g;
        end
    endgenerate

    generate
        if (L_CARE1) begin : g_edge
            logic ext_hist_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    ext_hist_q <= 1'b0;
                end else begin
                    ext_hist_q <= ext;
                end
            end

            assign out_d = ext & ~ext_hist_q;
        end else begin : g_level
            assign out_d = ext;
        end
    endgenerate

    logic out_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign o_pulse_dst = out_q;

endmodule

// File: tb/tb_cbb_pulse_synchronizer.sv
// tb/tb_cbb_pulse_synchronizer.sv - self-checking bench for cbb_pulse_synchronizer
module tb_cbb_pulse_synchronizer;

    localparam int N    = 5;
    localparam int MAXC = 4096;

    // Per-instance configuration, mirrored by the reference model below.
    localparam int S_T    [N] = '{2, 2, 2, 4, 3};
    localparam int M_T    [N] = '{3, 3, 3, 3, 5};
    localparam bit EN_T   [N] = '{1, 1, 0, 0, 1};
    localparam bit CARE_T [N] = '{1, 0, 0, 1, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic         src;
    logic [N-1:0] o;

    always #5 clk = ~clk;

    cbb_pulse_synchronizer #(.P_EXTEN_EN("ENABLE"),  .P_EXTEN_MULT(3), .P_SYNC_STAGE(2), .P_PULSE_WIDTH("CARE-1"))
        u_a (.i_clk(clk), .i_rst(rst), .i_pulse_src(src), .o_pulse_dst(o[0]));
    cbb_pulse_synchronizer #(.P_EXTEN_EN("ENABLE"),  .P_EXTEN_MULT(3), .P_SYNC_STAGE(2), .P_PULSE_WIDTH("NOTCARE"))
        u_b (.i_clk(clk), .i_rst(rst), .i_pulse_src(src), .o_pulse_dst(o[1]));
    cbb_pulse_synchronizer #(.P_EXTEN_EN("DISABLE"), .P_EXTEN_MULT(3), .P_SYNC_STAGE(2), .P_PULSE_WIDTH("NOTCARE"))
        u_c (.i_clk(clk), .i_rst(rst), .i_pulse_src(src), .o_pulse_dst(o[2]));
    cbb_pulse_synchronizer #(.P_EXTEN_EN("DISABLE"), .P_EXTEN_MULT(3), .P_SYNC_STAGE(4), .P_PULSE_WIDTH("CARE-1"))
        u_d (.i_clk(clk), .i_rst(rst), .i_pulse_src(src), .o_pulse_dst(o[3]));
    cbb_pulse_synchronizer #(.P_EXTEN_EN("ENABLE"),  .P_EXTEN_MULT(5), .P_SYNC_STAGE(3), .P_PULSE_WIDTH("CARE-1"))
        u_e (.i_clk(clk), .i_rst(rst), .i_pulse_src(src), .o_pulse_dst(o[4]));

    // History of what every edge sampled; the model works over these.
    bit in_h  [MAXC];
    bit rst_h [MAXC];
    int lr_h  [MAXC];   // index of the most recent reset edge at or before t
    int n = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt   [N];
    int first_hi [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Synchronized level after edge t: the input sampled S-1 edges earlier,
    // but only if that sample followed reset and a genuine low was seen
    // after reset before it (a level held across reset is discarded).
    function automatic bit m_sync(input int i, input int t);
        int idx;
        if (t < 0) return 1'b0;
        if (rst_h[t]) return 1'b0;
        idx = t - S_T[i] + 1;
        if (idx <= lr_h[t]) return 1'b0;
        if (!in_h[idx]) return 1'b0;
        for (int m = lr_h[t] + 1; m < idx; m++) begin
            if (!in_h[m]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Conditioned level: synchronized level, or within M cycles of a rising
    // edge of it (when stretching), with no reset in between.
    function automatic bit m_ext(input int i, input int t);
        if (t < 0) return 1'b0;
        if (rst_h[t]) return 1'b0;
        if (m_sync(i, t)) return 1'b1;
        if (!EN_T[i]) return 1'b0;
        for (int k = t - M_T[i] + 1; k <= t; k++) begin
            if (k > lr_h[t] && m_sync(i, k) && !m_sync(i, k - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_out(input int i, input int t);
        bit e1;
        bit e0;
        if (t < 1) return 1'b0;
        if (rst_h[t]) return 1'b0;
        e1 = m_ext(i, t - 1);
        if (!CARE_T[i]) return e1;
        e0 = (t < 2 || rst_h[t - 1]) ? 1'b0 : m_ext(i, t - 2);
        return e1 & ~e0;
    endfunction

    task automatic step(input bit v, input bit r);
        if (n >= MAXC) begin
            $display("FAIL history_overflow actual=%0d expected<%0d", n, MAXC);
            $fatal(1, "history overflow");
        end
        src = v;
        rst = r;
        @(posedge clk);
        in_h[n]  = v;
        rst_h[n] = r;
        lr_h[n]  = r ? n : ((n == 0) ? -1 : lr_h[n - 1]);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("model_u%0d_cyc%0d", i, n), {31'd0, o[i]}, {31'd0, m_out(i, n)});
            if (o[i] === 1'b1) begin
                hi_cnt[i]++;
                if (first_hi[i] < 0) first_hi[i] = n;
            end
        end
        n++;
    endtask

    task automatic clr_stats();
        for (int i = 0; i < N; i++) begin
            hi_cnt[i]   = 0;
            first_hi[i] = -1;
        end
    endtask

    initial begin
        int e1;
        bit lvl;
        int len;

        src = 1'b0;
        rst = 1'b1;
        clr_stats();

        repeat (3) step(1'b0, 1'b1);
        check("reset_out", {27'd0, o}, 32'd0);
        repeat (10) step(1'b0, 1'b0);

        // 2-cycle input across all configurations.
        clr_stats();
        e1 = n;
        repeat (2) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        check("care1_ext_hi",      hi_cnt[0],   1);
        check("care1_ext_first",   first_hi[0], e1 + 2);
        check("notcare_ext_hi",    hi_cnt[1],   3);
        check("notcare_ext_first", first_hi[1], e1 + 2);
        check("notcare_dis_hi2",   hi_cnt[2],   2);
        check("stage4_hi",         hi_cnt[3],   1);
        check("stage4_first",      first_hi[3], e1 + 4);
        check("stage3_mult5_hi",   hi_cnt[4],   1);

        // 5-cycle input: level tracks in bypass, still one pulse in CARE-1.
        clr_stats();
        e1 = n;
        repeat (5) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        check("notcare_dis_hi5",   hi_cnt[2],   5);
        check("notcare_dis_first", first_hi[2], e1 + 2);
        check("care1_long_hi",     hi_cnt[0],   1);
        check("notcare_ext_long",  hi_cnt[1],   5);

        // Gap of 1 inside the stretch window merges; gap of 4 does not.
        clr_stats();
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        check("merge_gap1",     hi_cnt[0], 1);
        check("nomerge_bypass", hi_cnt[3], 2);
        clr_stats();
        repeat (2) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        check("split_gap4", hi_cnt[0], 2);

        // Reset mid-event while the input stays high discards the event.
        clr_stats();
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_discard_u%0d", i), hi_cnt[i], 0);
        end
        clr_stats();
        e1 = n;
        repeat (2) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        check("post_rst_hi",    hi_cnt[0],   1);
        check("post_rst_first", first_hi[0], e1 + 2);

        // Random bursts with occasional resets, checked cycle by cycle.
        lvl = 1'b0;
        repeat (80) begin
            if ($urandom_range(0, 11) == 0) begin
                len = $urandom_range(1, 3);
                repeat (len) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                lvl = ~lvl;
                len = $urandom_range(1, 8);
                repeat (len) step(lvl, 1'b0);
            end
        end
        repeat (12) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
